// File: rtl/i_cache_sa_if.sv
// sram-like instruction bus between the cache (master) and the AXI bridge (slave).
// Read-only traffic: wr/size/wdata are driven constant by the cache.
interface i_cache_sa_if;
  logic        cache_inst_req;
  logic        cache_inst_wr;
  logic [1:0]  cache_inst_size;
  logic [31:0] cache_inst_addr;
  logic [31:0] cache_inst_wdata;
  logic [31:0] cache_inst_rdata;
  logic        cache_inst_addr_ok;
  logic        cache_inst_data_ok;

  modport master (
    output cache_inst_req, cache_inst_wr, cache_inst_size, cache_inst_addr, cache_inst_wdata,
    input  cache_inst_rdata, cache_inst_addr_ok, cache_inst_data_ok
  );

  modport slave (
    input  cache_inst_req, cache_inst_wr, cache_inst_size, cache_inst_addr, cache_inst_wdata,
    output cache_inst_rdata, cache_inst_addr_ok, cache_inst_data_ok
  );
endinterface

// File: rtl/i_cache_sa.sv
// Set-associative read-only instruction cache with word-by-word line refill,
// uncached bypass and a one-set-per-cycle whole-cache invalidate sweep.
module i_cache_sa #(
  parameter int WAYS         = 2,
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         cpu_inst_en,
  input  logic [31:0]  cpu_inst_addr,
  input  logic         cpu_inst_uncached,
  input  logic         cpu_inst_inval,
  output logic [31:0]  cpu_inst_rdata,
  output logic         i_stall,
  i_cache_sa_if.master bus
);

  localparam int SETS   = 1 << INDEX_WIDTH;
  localparam int WORDS  = 1 << (OFFSET_WIDTH - 2);
  localparam int WORD_W = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W  = 32 - INDEX_WIDTH - OFFSET_WIDTH;

  typedef enum logic [1:0] {IDLE, REFILL, UNCACHED, INVAL} state_t;

  state_t state;
  state_t state_next;

  logic [TAG_W-1:0]       tag_mem  [WAYS][SETS];
  logic [31:0]            data_mem [WAYS][SETS][WORDS];
  logic [SETS-1:0]        valid    [WAYS];
  logic [WAY_W-1:0]       rr_ptr   [SETS];

  logic [31:0]            miss_addr;
  logic [WAY_W-1:0]       victim;
  logic [WORD_W-1:0]      beat;
  logic                   req_done;
  logic                   inval_pending;
  logic [INDEX_WIDTH-1:0] sweep;

  logic [TAG_W-1:0]       cpu_tag;
  logic [INDEX_WIDTH-1:0] cpu_index;
  logic [WORD_W-1:0]      cpu_word;
  logic [TAG_W-1:0]       miss_tag;
  logic [INDEX_WIDTH-1:0] miss_index;
  logic [31:0]            line_addr;
  logic                   hit;
  logic [WAY_W-1:0]       hit_way;
  logic [WAY_W-1:0]       victim_next;
  logic                   last_beat;
  logic                   data_ok;

  assign cpu_tag    = cpu_inst_addr[31 -: TAG_W];
  assign cpu_index  = cpu_inst_addr[INDEX_WIDTH+OFFSET_WIDTH-1 : OFFSET_WIDTH];
  assign miss_tag   = miss_addr[31 -: TAG_W];
  assign miss_index = miss_addr[INDEX_WIDTH+OFFSET_WIDTH-1 : OFFSET_WIDTH];
  assign data_ok    = bus.cache_inst_data_ok;
  assign last_beat  = (beat == WORD_W'(WORDS - 1));

  generate
    if (OFFSET_WIDTH > 2) begin : g_word
      assign cpu_word = cpu_inst_addr[OFFSET_WIDTH-1:2];
    end else begin : g_word_single
      assign cpu_word = '0;
    end
  endgenerate

  // Refill beats walk the line from word 0 of the saved line address
  assign line_addr = {miss_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}}
                   | {{(30-WORD_W){1'b0}}, beat, 2'b00};

  assign bus.cache_inst_wr    = 1'b0;
  assign bus.cache_inst_size  = 2'b10;
  assign bus.cache_inst_wdata = 32'h0;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[w][cpu_index] && (tag_mem[w][cpu_index] == cpu_tag)) begin
        hit     = cpu_inst_en & ~cpu_inst_uncached;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins; otherwise the set's round-robin pointer
  always_comb begin
    victim_next = rr_ptr[cpu_index];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w][cpu_index]) begin
        victim_next = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cpu_inst_inval || inval_pending) begin
          state_next = INVAL;
        end else if (cpu_inst_en && cpu_inst_uncached) begin
          state_next = UNCACHED;
        end else if (cpu_inst_en && !hit) begin
          state_next = REFILL;
        end
      end
      REFILL: begin
        if (data_ok && last_beat) begin
          state_next = IDLE;
        end
      end
      UNCACHED: begin
        if (data_ok) begin
          state_next = IDLE;
        end
      end
      INVAL: begin
        if (sweep == INDEX_WIDTH'(SETS - 1)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.cache_inst_req  = 1'b0;
    bus.cache_inst_addr = line_addr;
    cpu_inst_rdata      = data_mem[hit_way][cpu_index][cpu_word];
    i_stall             = 1'b0;
    case (state)
      IDLE: begin
        i_stall = cpu_inst_en & ~hit;
      end
      REFILL: begin
        bus.cache_inst_req = ~req_done;
        i_stall            = cpu_inst_en;
      end
      UNCACHED: begin
        bus.cache_inst_req  = ~req_done;
        bus.cache_inst_addr = miss_addr;
        cpu_inst_rdata      = bus.cache_inst_rdata;
        i_stall             = cpu_inst_en & ~data_ok;
      end
      INVAL: begin
        i_stall = 1'b1;
      end
      default: i_stall = 1'b1;
    endcase
  end

  // Control state, valid bits and replacement pointers share the async reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      miss_addr     <= '0;
      victim        <= '0;
      beat          <= '0;
      req_done      <= 1'b0;
      inval_pending <= 1'b0;
      sweep         <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) begin
        rr_ptr[s] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          beat     <= '0;
          req_done <= 1'b0;
          sweep    <= '0;
          if (state_next == INVAL) begin
            inval_pending <= 1'b0;
          end
          if ((state_next == REFILL) || (state_next == UNCACHED)) begin
            miss_addr <= cpu_inst_addr;
          end
          if (state_next == REFILL) begin
            victim                         <= victim_next;
            valid[victim_next][cpu_index]  <= 1'b0;
          end
        end
        REFILL, UNCACHED: begin
          if (cpu_inst_inval) begin
            inval_pending <= 1'b1;
          end
          if (bus.cache_inst_req && bus.cache_inst_addr_ok) begin
            req_done <= 1'b1;
          end
          if (data_ok) begin
            req_done <= 1'b0;
            if (state == REFILL) begin
              beat <= last_beat ? '0 : beat + WORD_W'(1);
              if (last_beat) begin
                valid[victim][miss_index] <= 1'b1;
                rr_ptr[miss_index] <= (rr_ptr[miss_index] == WAY_W'(WAYS - 1))
                                    ? '0 : rr_ptr[miss_index] + WAY_W'(1);
              end
            end
          end
        end
        INVAL: begin
          for (int w = 0; w < WAYS; w++) begin
            valid[w][sweep] <= 1'b0;
          end
          sweep <= sweep + INDEX_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Data and tag arrays carry no reset; valid bits guard their contents
  always_ff @(posedge clk) begin
    if ((state == REFILL) && data_ok) begin
      data_mem[victim][miss_index][beat] <= bus.cache_inst_rdata;
      if (last_beat) begin
        tag_mem[victim][miss_index] <= miss_tag;
      end
    end
  end

endmodule
